code_lock: RTL

Parametrised keypad code lock: it captures NUM_DIGITS BCD digits from a 10-key pad, compares them against a stored code on OPEN, and lets the code be rewritten only while unlocked. Repeated wrong attempts trigger a timed lockout. It supersedes the fixed 3-digit lock in the access-control design, sitting between the keypad debouncer and the lock actuator and display drivers.

---
 rtl/code_lock_pkg.sv | 28 ++
 rtl/code_lock_seg7_decode.sv | 19 +
 rtl/code_lock.sv | 137 +++++++++++++
 3 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the keypad code lock.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPENED  = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  // Seven-segment patterns, bit 6 = segment a ... bit 0 = segment g; entry 10 is blank.
  localparam int SEG_BLANK = 10;
  localparam logic [10:0][6:0] SEG_TBL = {
    7'b0000000,  // blank
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/code_lock_seg7_decode.sv
// Registered single-digit BCD to seven-segment decoder.
// Only compiled when CODE_LOCK_SEG_EN is defined, since nothing else uses it.
`ifdef CODE_LOCK_SEG_EN
module seg7_decode
  import code_lock_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  bcd_t       i_digit,
  output logic [6:0] o_seg
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_seg <= '0;
    else          o_seg <= (i_digit > 4'd9) ? SEG_TBL[SEG_BLANK] : SEG_TBL[i_digit];
  end

endmodule
`endif

// File: rtl/code_lock.sv
// Keypad code lock with programmable code and timed lockout after repeated failures.
// Define CODE_LOCK_SEG_EN to build per-digit seven-segment decoders on o_seg.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [9:0]              i_key,
  input  logic                    i_open,
  input  logic                    i_close,
  input  logic                    i_set,
  output logic                    o_unlocked,
  output logic                    o_lockout,
  output logic [3:0]              o_fail_cnt,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_entry_full,
  output logic [7*NUM_DIGITS-1:0] o_seg
);

  localparam int PW = $clog2(NUM_DIGITS + 1);
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

  state_t                  r_state, w_state_nxt;
  bcd_t [NUM_DIGITS-1:0]   r_dig, w_dig_nxt, r_code, w_code_nxt;
  logic [PW-1:0]           r_pos, w_pos_nxt;
  logic [3:0]              r_fail, w_fail_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    r_key_any;
  logic                    w_onehot, w_full, w_key_evt, w_set_ok, w_open_ok;
  bcd_t                    w_key_dig;

  always_comb begin
    w_key_dig = '0;
    for (int i = 0; i < 10; i++)
      if (i_key[i]) w_key_dig = 4'(i);
  end

  assign w_onehot  = (i_key != '0) && ((i_key & (i_key - 10'd1)) == '0);
  assign w_full    = (r_pos == PW'(NUM_DIGITS));
  // A press only counts (and only wins priority) when it can actually be stored.
  assign w_key_evt = w_onehot && !r_key_any && !w_full && (r_state != ST_LOCKOUT);
  assign w_set_ok  = i_set && w_full && (r_state == ST_OPENED);
  assign w_open_ok = i_open && w_full && (r_state == ST_LOCKED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_LOCKED;
      r_dig     <= '0;
      r_code    <= '0;
      r_pos     <= '0;
      r_fail    <= '0;
      r_cnt     <= '0;
      r_key_any <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dig     <= w_dig_nxt;
      r_code    <= w_code_nxt;
      r_pos     <= w_pos_nxt;
      r_fail    <= w_fail_nxt;
      r_cnt     <= w_cnt_nxt;
      r_key_any <= |i_key;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_code_nxt  = r_code;
    w_pos_nxt   = r_pos;
    w_fail_nxt  = r_fail;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_LOCKOUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LOCKED;
          w_fail_nxt  = '0;
          w_dig_nxt   = '0;
          w_pos_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        if (w_key_evt) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (r_pos == PW'(i)) w_dig_nxt[i] = w_key_dig;
          w_pos_nxt = r_pos + 1'b1;
        end else if (w_set_ok) begin
          w_code_nxt = r_dig;
          w_dig_nxt  = '0;
          w_pos_nxt  = '0;
        end else if (i_close) begin
          w_state_nxt = ST_LOCKED;
          w_dig_nxt   = '0;
          w_pos_nxt   = '0;
        end else if (w_open_ok) begin
          w_dig_nxt = '0;
          w_pos_nxt = '0;
          if (r_dig == r_code) begin
            w_state_nxt = ST_OPENED;
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt = r_fail + 4'd1;
            if (r_fail + 4'd1 >= 4'(MAX_TRIES)) begin
              w_state_nxt = ST_LOCKOUT;
              w_cnt_nxt   = CW'(LOCKOUT_CYCLES - 1);
            end
          end
        end
      end
    endcase
  end

  assign o_unlocked   = (r_state == ST_OPENED);
  assign o_lockout    = (r_state == ST_LOCKOUT);
  assign o_fail_cnt   = r_fail;
  assign o_digits     = r_dig;
  assign o_entry_full = w_full;

`ifdef CODE_LOCK_SEG_EN
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    seg7_decode u_seg (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_digit (r_dig[g]),
      .o_seg   (o_seg[g*7 +: 7])
    );
  end
`else
  assign o_seg = '0;
`endif

endmodule
